// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - size encodings, FSM state type and lane/extend helpers for mem_stage.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_t;

    // Size 2'b11 falls through to the word case everywhere below.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: lane_mask = BE_BYTE << lo;
            SZ_HALF: lane_mask = lo[1] ? (BE_HALF << 2) : BE_HALF;
            default: lane_mask = BE_WORD;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
        case (size)
            SZ_BYTE: store_lanes = {4{data[7:0]}};
            SZ_HALF: store_lanes = {2{data[15:0]}};
            default: store_lanes = data;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lo, input logic uns);
        logic [31:0] sh;
        sh = word >> {lo, 3'b000};
        case (size)
            SZ_BYTE: load_extend = uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: load_extend = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: load_extend = word;
        endcase
    endfunction

    function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: align_lo = lo;
            SZ_HALF: align_lo = {lo[1], 1'b0};
            default: align_lo = 2'b00;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = lo[0];
            default: is_misaligned = (lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/data_memory_bank.sv
// rtl/data_memory_bank.sv - byte-enable write, synchronous read word memory cleared on reset.
module data_memory_bank #(
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [2**ADDR_W];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 2**ADDR_W; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[addr_i];
            if (we_i) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_i[b]) begin
                        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline MEM stage: branch select, multi-cycle load/store with stall.
// Optional MEM_STAGE_MISALIGN_TRAP_EN: flag and suppress misaligned accesses instead of aligning them.
module mem_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        branch,
    input  logic        branch_ne,
    input  logic        alu_zero,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [31:0] alu_res,
    input  logic [31:0] rt_data,
    output logic        pc_source,
    output logic        stall,
    output logic [31:0] read_data,
    output logic        misalign_fault
);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [31:0]        read_data_q, read_data_d;
    logic               fault_q, fault_d;
    logic               req, mem_we, misaligned;
    logic [1:0]         lo;
    logic [ADDR_W-1:0]  widx;
    logic [31:0]        bank_rdata;
    logic               unused_hi;

    assign req       = mem_read | mem_write;
    assign pc_source = branch & (alu_zero ^ branch_ne);
    assign widx      = alu_res[ADDR_W+1:2];
    assign unused_hi = ^alu_res[31:ADDR_W+2];

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    assign lo         = alu_res[1:0];
    assign misaligned = is_misaligned(size, alu_res[1:0]);
`else
    assign lo         = align_lo(size, alu_res[1:0]);
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            read_data_q <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            read_data_q <= read_data_d;
            fault_q     <= fault_d;
        end
    end

    // The access completes on the edge where the decremented count reaches zero,
    // so a request seen in cycle 0 delivers its result in cycle MEM_LAT.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        read_data_d = read_data_q;
        fault_d     = fault_q;
        stall       = 1'b0;
        mem_we      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    stall   = 1'b1;
                    state_d = ST_ACCESS;
                    cnt_d   = 4'(MEM_LAT - 1);
                end
            end
            ST_ACCESS: begin
                stall = 1'b1;
                cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
                if (cnt_d == 4'd0) begin
                    state_d = ST_DONE;
                    fault_d = misaligned;
                    if (!misaligned) begin
                        if (mem_write) begin
                            mem_we = 1'b1;
                        end else begin
                            read_data_d = load_extend(bank_rdata, size, lo, unsigned_ld);
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    data_memory_bank #(
        .ADDR_W(ADDR_W)
    ) data_memory (
        .clk_i  (clk),
        .rst_ni (reset),
        .we_i   (mem_we),
        .be_i   (lane_mask(size, lo)),
        .addr_i (widx),
        .wdata_i(store_lanes(size, rt_data)),
        .rdata_o(bank_rdata)
    );

    assign read_data      = read_data_q;
    assign misalign_fault = fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage (ADDR_W=4, MEM_LAT=2).
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        branch, branch_ne, alu_zero;
    logic        mem_read, mem_write;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [31:0] alu_res, rt_data;
    logic        pc_source, stall, misalign_fault;
    logic [31:0] read_data;

    int          checks = 0;
    int          errors = 0;
    int          n_stall;
    logic [31:0] rd_done;
    logic        fault_done;

    mem_stage dut (
        .clk           (clk),
        .reset         (reset),
        .branch        (branch),
        .branch_ne     (branch_ne),
        .alu_zero      (alu_zero),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .size          (size),
        .unsigned_ld   (unsigned_ld),
        .alu_res       (alu_res),
        .rt_data       (rt_data),
        .pc_source     (pc_source),
        .stall         (stall),
        .read_data     (read_data),
        .misalign_fault(misalign_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_req();
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        size        = 2'b10;
        unsigned_ld = 1'b0;
        alu_res     = '0;
        rt_data     = '0;
    endtask

    // Called at posedge+1 with the stage idle; returns at posedge+1 after DONE.
    task automatic mem_op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
        logic got_done;
        mem_read    = rd;
        mem_write   = wr;
        size        = sz;
        unsigned_ld = uns;
        alu_res     = addr;
        rt_data     = wdata;
        n_stall     = 0;
        got_done    = 1'b0;
        for (int i = 0; i < 20 && !got_done; i++) begin
            @(negedge clk);
            if (stall) n_stall++;
            else got_done = 1'b1;
        end
        rd_done    = read_data;
        fault_done = misalign_fault;
        check("op_completes", {31'd0, got_done}, 32'd1);
        @(posedge clk);
        #1;
        clear_req();
    endtask

    initial begin
        reset     = 1'b0;
        branch    = 1'b0;
        branch_ne = 1'b0;
        alu_zero  = 1'b0;
        clear_req();
        #2;
        check("rst_read_data", read_data, 32'h0);
        check("rst_fault", {31'd0, misalign_fault}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;

        branch = 1'b1; branch_ne = 1'b1; alu_zero = 1'b0; #1;
        check("bne_taken", {31'd0, pc_source}, 32'd1);
        alu_zero = 1'b1; #1;
        check("bne_not_taken", {31'd0, pc_source}, 32'd0);
        branch_ne = 1'b0; #1;
        check("beq_taken", {31'd0, pc_source}, 32'd1);
        branch = 1'b0; #1;
        check("no_branch", {31'd0, pc_source}, 32'd0);
        alu_zero = 1'b0;
        @(posedge clk);
        #1;

        mem_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h8, 32'h12345678);
        check("sw_stall_cycles", n_stall, 32'd2);
        check("sw_keeps_read_data", rd_done, 32'h0);
        mem_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        check("lw_stall_cycles", n_stall, 32'd2);
        check("lw_0x8", rd_done, 32'h12345678);

        mem_op(1'b0, 1'b1, 2'b00, 1'b0, 32'h9, 32'h000000AB);
        mem_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h9, 32'h0);
        check("lb_0x9", rd_done, 32'hFFFFFFAB);
        mem_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h9, 32'h0);
        check("lbu_0x9", rd_done, 32'h000000AB);
        mem_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        check("lw_after_sb", rd_done, 32'h1234AB78);

        mem_op(1'b1, 1'b0, 2'b01, 1'b0, 32'hA, 32'h0);
        check("lh_0xA_pos", rd_done, 32'h00001234);
        mem_op(1'b0, 1'b1, 2'b01, 1'b0, 32'hA, 32'h00008000);
        mem_op(1'b1, 1'b0, 2'b01, 1'b0, 32'hA, 32'h0);
        check("lh_0xA_neg", rd_done, 32'hFFFF8000);
        mem_op(1'b1, 1'b0, 2'b01, 1'b1, 32'hA, 32'h0);
        check("lhu_0xA", rd_done, 32'h00008000);
        mem_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h8, 32'h0);
        check("lw_sz11_after_sh", rd_done, 32'h8000AB78);

        mem_op(1'b1, 1'b1, 2'b10, 1'b0, 32'hC, 32'hCAFEF00D);
        check("rw_is_store_rd_kept", rd_done, 32'h8000AB78);
        mem_op(1'b1, 1'b0, 2'b10, 1'b0, 32'hC, 32'h0);
        check("lw_0xC", rd_done, 32'hCAFEF00D);

        mem_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h11112222);
        mem_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        check("wrap_lw_0x0", rd_done, 32'h11112222);

        mem_op(1'b0, 1'b1, 2'b10, 1'b0, 32'h6, 32'hDEADBEEF);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        check("misalign_fault_sw6", {31'd0, fault_done}, 32'd1);
        mem_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        check("misalign_mem_unchanged", rd_done, 32'h0);
`else
        check("misalign_fault_sw6", {31'd0, fault_done}, 32'd0);
        mem_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        check("aligned_lw_0x4", rd_done, 32'hDEADBEEF);
`endif
        check("fault_after_aligned", {31'd0, fault_done}, 32'd0);

        @(negedge clk);
        check("no_mem_no_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        mem_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        check("lw_0x0_before_reset", rd_done, 32'h11112222);

        mem_read  = 1'b0;
        mem_write = 1'b1;
        size      = 2'b10;
        alu_res   = 32'h4;
        rt_data   = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("access_stall", {31'd0, stall}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("abort_read_data", read_data, 32'h0);
        check("abort_fault", {31'd0, misalign_fault}, 32'd0);
        clear_req();
        #1;
        check("abort_idle_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        mem_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        check("abort_no_commit_0x4", rd_done, 32'h0);
        mem_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        check("reset_cleared_0x8", rd_done, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
